rv32i_alu_arbiter: RTL and testbench

Shares a single RV32I ALU datapath between two requesters: port 0 for the execute stage and port 1 for an auxiliary unit such as CSR/debug address arithmetic. Each cycle a round-robin arbiter grants at most one request. The granted operation is computed in the shared ALU and its result is queued in a 2-entry response FIFO. Results are returned in grant order, tagged with the requester id.

---
 rtl/rv32i_alu_arbiter.sv | 148 ++++++++++++++
 tb/tb_rv32i_alu_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_alu_arbiter.sv
// rv32i_alu_arbiter: two requesters share one RV32I ALU through a round-robin
// arbiter. Each granted op is computed combinationally and its result is queued
// in a 2-entry FIFO, so responses come back in grant order tagged with the id.
module rv32i_alu_arbiter #(
    parameter int ALU_W = 14
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [ALU_W-1:0] i_req0_op,
    input  logic [31:0]      i_req0_a,
    input  logic [31:0]      i_req0_b,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [ALU_W-1:0] i_req1_op,
    input  logic [31:0]      i_req1_a,
    input  logic [31:0]      i_req1_b,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [31:0]      o_rsp_y,
    output logic             o_rsp_err
);

    // one-hot op bit positions
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_XOR  = 4;
    localparam int OP_OR   = 5;
    localparam int OP_AND  = 6;
    localparam int OP_SLL  = 7;
    localparam int OP_SRL  = 8;
    localparam int OP_SRA  = 9;
    localparam int OP_EQ   = 10;
    localparam int OP_NEQ  = 11;
    localparam int OP_GE   = 12;
    localparam int OP_GEU  = 13;

    typedef struct packed {
        logic        id;
        logic [31:0] y;
        logic        err;
    } rsp_t;

    rsp_t             fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             last_grant;

    logic             space;
    logic             grant0;
    logic             grant1;
    logic             push;
    logic             pop;

    logic [ALU_W-1:0] sel_op;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic             op_legal;
    logic [31:0]      alu_y;
    logic             alu_err;
    rsp_t             head;

    // A pop in this cycle frees a slot for a same-cycle push.
    assign pop   = o_rsp_valid && i_rsp_ready;
    assign space = (count < 2'd2) || pop;

    // Round-robin: on a tie the port that did not win last time goes first.
    // Readies are held low during reset so nothing is accepted then.
    assign grant0 = !i_rst && space && i_req0_valid && (!i_req1_valid || last_grant);
    assign grant1 = !i_rst && space && i_req1_valid && (!i_req0_valid || !last_grant);
    assign push   = grant0 || grant1;

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;

    assign sel_op = grant1 ? i_req1_op : i_req0_op;
    assign sel_a  = grant1 ? i_req1_a  : i_req0_a;
    assign sel_b  = grant1 ? i_req1_b  : i_req0_b;

    // exactly one bit set: nonzero and clearing the lowest set bit leaves zero
    assign op_legal = (sel_op != '0) && ((sel_op & (sel_op - ALU_W'(1))) == '0);

    // Shared ALU; non-one-hot ops produce y=0 with err raised.
    always_comb begin
        alu_y   = '0;
        alu_err = 1'b0;
        if (!op_legal) begin
            alu_err = 1'b1;
        end else begin
            case (1'b1)
                sel_op[OP_ADD]:  alu_y = sel_a + sel_b;
                sel_op[OP_SUB]:  alu_y = sel_a - sel_b;
                sel_op[OP_SLT]:  alu_y = {31'b0, $signed(sel_a) < $signed(sel_b)};
                sel_op[OP_SLTU]: alu_y = {31'b0, sel_a < sel_b};
                sel_op[OP_XOR]:  alu_y = sel_a ^ sel_b;
                sel_op[OP_OR]:   alu_y = sel_a | sel_b;
                sel_op[OP_AND]:  alu_y = sel_a & sel_b;
                sel_op[OP_SLL]:  alu_y = sel_a << sel_b[4:0];
                sel_op[OP_SRL]:  alu_y = sel_a >> sel_b[4:0];
                sel_op[OP_SRA]:  alu_y = $signed(sel_a) >>> sel_b[4:0];
                sel_op[OP_EQ]:   alu_y = {31'b0, sel_a == sel_b};
                sel_op[OP_NEQ]:  alu_y = {31'b0, sel_a != sel_b};
                sel_op[OP_GE]:   alu_y = {31'b0, $signed(sel_a) >= $signed(sel_b)};
                sel_op[OP_GEU]:  alu_y = {31'b0, sel_a >= sel_b};
                default:         alu_y = '0;
            endcase
        end
    end

    // Arbiter state and response FIFO; storage is cleared on reset so the
    // response outputs read as zero while reset is held.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            last_grant  <= 1'b1;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{id: grant1, y: alu_y, err: alu_err};
                wr_ptr           <= ~wr_ptr;
                last_grant       <= grant1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head        = fifo_mem[rd_ptr];
    assign o_rsp_valid = (count != 2'd0);
    assign o_rsp_id    = head.id;
    assign o_rsp_y     = head.y;
    assign o_rsp_err   = head.err;

endmodule

// File: tb/tb_rv32i_alu_arbiter.sv
// tb_rv32i_alu_arbiter: per-port request queues drive the DUT; accepted
// requests push a reference result to a scoreboard that is popped and compared
// whenever the DUT hands out a response. A small arbiter/count model checks
// the readies and o_rsp_valid every cycle.
module tb_rv32i_alu_arbiter;

    localparam int ALU_W = 14;

    typedef struct {
        logic [ALU_W-1:0] op;
        logic [31:0]      a;
        logic [31:0]      b;
    } req_t;

    typedef struct {
        logic        id;
        logic [31:0] y;
        logic        err;
    } rsp_t;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_req0_valid = 1'b0;
    logic             o_req0_ready;
    logic [ALU_W-1:0] i_req0_op = '0;
    logic [31:0]      i_req0_a = '0;
    logic [31:0]      i_req0_b = '0;
    logic             i_req1_valid = 1'b0;
    logic             o_req1_ready;
    logic [ALU_W-1:0] i_req1_op = '0;
    logic [31:0]      i_req1_a = '0;
    logic [31:0]      i_req1_b = '0;
    logic             o_rsp_valid;
    logic             i_rsp_ready = 1'b0;
    logic             o_rsp_id;
    logic [31:0]      o_rsp_y;
    logic             o_rsp_err;

    rv32i_alu_arbiter #(.ALU_W(ALU_W)) u_dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req0_valid (i_req0_valid),
        .o_req0_ready (o_req0_ready),
        .i_req0_op    (i_req0_op),
        .i_req0_a     (i_req0_a),
        .i_req0_b     (i_req0_b),
        .i_req1_valid (i_req1_valid),
        .o_req1_ready (o_req1_ready),
        .i_req1_op    (i_req1_op),
        .i_req1_a     (i_req1_a),
        .i_req1_b     (i_req1_b),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_y      (o_rsp_y),
        .o_rsp_err    (o_rsp_err)
    );

    always #5 i_clk = ~i_clk;

    req_t pend0[$];
    req_t pend1[$];
    rsp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_count = 0;
    logic m_last  = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Reference ALU, decoded by bit index.
    function automatic rsp_t ref_alu(input logic id, input req_t r);
        rsp_t o;
        int   k;
        o.id = id; o.y = '0; o.err = 1'b0; k = -1;
        if ($countones(r.op) != 1) begin
            o.err = 1'b1;
            return o;
        end
        for (int i = 0; i < ALU_W; i++) if (r.op[i]) k = i;
        case (k)
            0:  o.y = r.a + r.b;
            1:  o.y = r.a - r.b;
            2:  o.y = ($signed(r.a) < $signed(r.b)) ? 32'd1 : 32'd0;
            3:  o.y = (r.a < r.b) ? 32'd1 : 32'd0;
            4:  o.y = r.a ^ r.b;
            5:  o.y = r.a | r.b;
            6:  o.y = r.a & r.b;
            7:  o.y = r.a << r.b[4:0];
            8:  o.y = r.a >> r.b[4:0];
            9:  o.y = $unsigned($signed(r.a) >>> r.b[4:0]);
            10: o.y = (r.a == r.b) ? 32'd1 : 32'd0;
            11: o.y = (r.a != r.b) ? 32'd1 : 32'd0;
            12: o.y = ($signed(r.a) >= $signed(r.b)) ? 32'd1 : 32'd0;
            default: o.y = (r.a >= r.b) ? 32'd1 : 32'd0;
        endcase
        return o;
    endfunction

    task automatic req(input int port, input logic [ALU_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_t r;
        r.op = op; r.a = a; r.b = b;
        if (port == 0) pend0.push_back(r);
        else           pend1.push_back(r);
    endtask

    // One clock: drive heads of the request queues, check at negedge, advance.
    task automatic step();
        logic v0, v1, sp, g0, g1, mpop;
        rsp_t e;
        v0 = (pend0.size() != 0);
        v1 = (pend1.size() != 0);
        i_req0_valid = v0;
        i_req1_valid = v1;
        i_req0_op = v0 ? pend0[0].op : '0; i_req0_a = v0 ? pend0[0].a : '0; i_req0_b = v0 ? pend0[0].b : '0;
        i_req1_op = v1 ? pend1[0].op : '0; i_req1_a = v1 ? pend1[0].a : '0; i_req1_b = v1 ? pend1[0].b : '0;
        @(negedge i_clk);
        if (i_rst) begin
            chk("rst_rdy0", 32'(o_req0_ready), 32'd0);
            chk("rst_rdy1", 32'(o_req1_ready), 32'd0);
            chk("rst_vld",  32'(o_rsp_valid), 32'd0);
            sb.delete();
            m_count = 0;
            m_last  = 1'b1;
        end else begin
            sp = (m_count < 2) || (m_count != 0 && i_rsp_ready);
            g0 = sp && v0 && (!v1 || m_last);
            g1 = sp && v1 && (!v0 || !m_last);
            chk("rdy0", 32'(o_req0_ready), 32'(g0));
            chk("rdy1", 32'(o_req1_ready), 32'(g1));
            chk("vld",  32'(o_rsp_valid), 32'(m_count != 0));
            mpop = (m_count != 0) && i_rsp_ready;
            if (mpop) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("id",  32'(o_rsp_id), 32'(e.id));
                    chk("y",   o_rsp_y, e.y);
                    chk("err", 32'(o_rsp_err), 32'(e.err));
                end
                m_count--;
            end
            if (o_req0_ready && v0) begin
                sb.push_back(ref_alu(1'b0, pend0.pop_front()));
                m_last = 1'b0;
                m_count++;
            end else if (o_req1_ready && v1) begin
                sb.push_back(ref_alu(1'b1, pend1.pop_front()));
                m_last = 1'b1;
                m_count++;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((sb.size() != 0 || pend0.size() != 0 || pend1.size() != 0) && n < max_cycles) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(sb.size() + pend0.size() + pend1.size()), 32'd0);
    endtask

    initial begin
        // reset state
        i_rst = 1'b1;
        step();
        chk("rst_id",  32'(o_rsp_id), 32'd0);
        chk("rst_y",   o_rsp_y, 32'd0);
        chk("rst_err", 32'(o_rsp_err), 32'd0);
        step();
        i_rst = 1'b0;
        i_rsp_ready = 1'b1;

        // single ADD with wraparound on port 0
        req(0, 14'h0001, 32'hFFFF_FFFF, 32'd1);
        drain(10);

        // both ports busy: SUB on 0, SRA on 1, grants alternate
        for (int i = 0; i < 4; i++) begin
            req(0, 14'h0002, 32'd5, 32'd7);
            req(1, 14'h0200, 32'h8000_0000, 32'd4);
        end
        drain(20);

        // signed vs unsigned compares and the remaining ops
        req(0, 14'h0004, 32'hFFFF_FFFF, 32'd1);
        req(0, 14'h0008, 32'hFFFF_FFFF, 32'd1);
        req(0, 14'h1000, 32'hFFFF_FFFF, 32'd1);
        req(0, 14'h2000, 32'hFFFF_FFFF, 32'd1);
        req(1, 14'h0010, 32'hF0F0_1234, 32'h0FF0_FFFF);
        req(1, 14'h0020, 32'hF0F0_1234, 32'h0FF0_0000);
        req(1, 14'h0040, 32'hF0F0_1234, 32'h0FF0_FFFF);
        req(1, 14'h0080, 32'h0000_0003, 32'd33);
        req(1, 14'h0100, 32'h8000_0000, 32'd31);
        req(1, 14'h0400, 32'h1234_5678, 32'h1234_5678);
        req(1, 14'h0800, 32'h1234_5678, 32'h1234_5678);
        drain(40);

        // illegal ops on port 1
        req(1, 14'h0000, 32'd9, 32'd9);
        req(1, 14'h0003, 32'd9, 32'd9);
        drain(10);

        // backpressure: FIFO fills, then same-cycle pop+push
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) req(1, 14'h0001, 32'(i * 100), 32'd1);
        repeat (4) step();
        i_rsp_ready = 1'b1;
        drain(20);

        // reset with a full FIFO and both ports waiting
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req(0, 14'h0001, 32'(i), 32'd10);
            req(1, 14'h0002, 32'(i), 32'd10);
        end
        repeat (3) step();
        i_rst = 1'b1;
        #1;
        chk("async_rst_vld", 32'(o_rsp_valid), 32'd0);
        chk("async_rst_id",  32'(o_rsp_id), 32'd0);
        chk("async_rst_y",   o_rsp_y, 32'd0);
        chk("async_rst_err", 32'(o_rsp_err), 32'd0);
        step();
        i_rst = 1'b0;
        i_rsp_ready = 1'b1;
        drain(30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
